// File: rtl/piso_serializer8.sv
// Parallel-in/serial-out stage: accepts a word on a valid/ready handshake and shifts it
// out one bit per clock, optionally followed by an even/odd parity bit.
module piso_serializer8 #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int PARITY    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PI,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  output logic             so,
  output logic             so_valid,
  output logic             last
);

  localparam int N  = WIDTH + ((PARITY != 0) ? 1 : 0);
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_par;
  logic             r_so, r_so_valid, r_last;

  logic             w_accept, w_adv, w_done;
  logic [WIDTH-1:0] w_ord;
  logic             w_par;
  logic [CW-1:0]    w_cnt_inc;

  assign in_ready  = (r_state == IDLE) && rst;
  assign so        = r_so;
  assign so_valid  = r_so_valid;
  assign last      = r_last;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_par     = (PARITY == 2) ? ~^PI : ^PI;

  // Word is stored in transmit order so the shifter always emits from bit 0.
  always_comb begin
    w_ord = PI;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++) w_ord[i] = PI[WIDTH-1-i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_adv       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!stall) begin
          if (r_last) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // so always mirrors r_shreg[0] for data bits; the parity bit follows the data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_par      <= 1'b0;
      r_so       <= 1'b0;
      r_so_valid <= 1'b0;
      r_last     <= 1'b0;
    end else if (w_accept) begin
      r_shreg    <= w_ord;
      r_par      <= w_par;
      r_cnt      <= '0;
      r_so       <= w_ord[0];
      r_so_valid <= 1'b1;
      r_last     <= 1'b0;
    end else if (w_adv) begin
      r_shreg    <= r_shreg >> 1;
      r_cnt      <= w_cnt_inc;
      r_so       <= (w_cnt_inc < CW'(WIDTH)) ? r_shreg[1] : r_par;
      r_last     <= (w_cnt_inc == CW'(N - 1));
    end else if (w_done) begin
      r_cnt      <= '0;
      r_so       <= 1'b0;
      r_so_valid <= 1'b0;
      r_last     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serializer8.sv
// Bench for piso_serializer8: three parameterizations driven in lockstep and checked
// every cycle against a frame-queue reference model.
module tb_piso_serializer8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] PI;
  logic       in_valid;
  logic       stall;
  logic [2:0] in_ready_v, so_v, so_valid_v, last_v;

  int n_chk = 0;
  int n_err = 0;

  // instance i: MSB_FIRST / PARITY
  int MSB[3] = '{0, 1, 1};
  int PAR[3] = '{0, 1, 2};

  // model: bits still to be shown, head is the bit on so
  bit q[3][$];
  bit active[3];

  always #5 clk = ~clk;

  piso_serializer8 #(.WIDTH(8), .MSB_FIRST(0), .PARITY(0)) u0 (
    .clk(clk), .rst(rst), .PI(PI), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .stall(stall), .so(so_v[0]), .so_valid(so_valid_v[0]), .last(last_v[0]));
  piso_serializer8 #(.WIDTH(8), .MSB_FIRST(1), .PARITY(1)) u1 (
    .clk(clk), .rst(rst), .PI(PI), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .stall(stall), .so(so_v[1]), .so_valid(so_valid_v[1]), .last(last_v[1]));
  piso_serializer8 #(.WIDTH(8), .MSB_FIRST(1), .PARITY(2)) u2 (
    .clk(clk), .rst(rst), .PI(PI), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .stall(stall), .so(so_v[2]), .so_valid(so_valid_v[2]), .last(last_v[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int i);
    if (!rst) begin
      q[i].delete();
      active[i] = 1'b0;
    end else if (!active[i]) begin
      if (in_valid) begin
        q[i].delete();
        for (int k = 0; k < 8; k++) q[i].push_back(MSB[i] != 0 ? PI[7-k] : PI[k]);
        if (PAR[i] != 0) q[i].push_back(bit'($countones(PI) % 2) ^ (PAR[i] == 2));
        active[i] = 1'b1;
      end
    end else if (!stall) begin
      void'(q[i].pop_front());
      if (q[i].size() == 0) active[i] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.so_valid", i), so_valid_v[i], active[i]);
      chk($sformatf("u%0d.so", i), so_v[i], active[i] ? q[i][0] : 1'b0);
      chk($sformatf("u%0d.last", i), last_v[i], active[i] && q[i].size() == 1);
      chk($sformatf("u%0d.in_ready", i), in_ready_v[i], !active[i] && rst);
    end
  endtask

  logic [7:0] cap0;
  logic [8:0] cap1, cap2;

  initial begin
    for (int i = 0; i < 3; i++) active[i] = 1'b0;
    rst = 1'b0; PI = 8'h94; in_valid = 1'b1; stall = 1'b0;
    // reset with a word offered: nothing starts
    step(); step();
    rst = 1'b1; in_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("rel.in_ready%0d", i), in_ready_v[i], 1'b1);
    step();

    // 0x94 in all three orderings / parities
    PI = 8'h94; in_valid = 1'b1;
    step();
    in_valid = 1'b0; PI = 8'h00;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) cap0[k] = so_v[0];
      cap1[k] = so_v[1];
      cap2[k] = so_v[2];
      step();
    end
    chk("t2.lsb_word", cap0, 8'h94);
    chk("t3.even_frame", cap1, 9'b100101001);
    chk("t3.odd_frame", cap2, 9'b000101001);
    step(); step();

    // stall for 3 cycles while bit 3 is on so
    PI = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    stall = 1'b1;
    step(); step(); step();
    stall = 1'b0;
    repeat (8) step();

    // reset while bit 4 is on so, then a fresh all-ones word
    PI = 8'h3C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    step();
    rst = 1'b1; PI = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();

    // in_valid held across a frame, PI changes mid-frame
    PI = 8'h01; in_valid = 1'b1;
    step();
    step(); step();
    PI = 8'h80;
    repeat (20) step();
    in_valid = 1'b0;
    repeat (12) step();

    // stall on the last bit
    PI = 8'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    repeat (4) step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 99) >= 3);
      in_valid = $urandom_range(0, 1);
      stall    = ($urandom_range(0, 3) == 0);
      PI       = 8'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
